// File: rtl/cmp_serial_arb.sv
// Serial W-bit unsigned magnitude comparator shared by two requesters.
// One 2-bit digit pair per cycle, MSB first, early exit on the first unequal pair.
module cmp_serial_arb #(
   parameter int W = 10,
   parameter int D = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic [1:0]   gnt,
   output logic         busy,
   output logic         done,
   output logic         done_id,
   output logic         g,
   output logic         e
);

   localparam int N  = W / D;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (W < 2 || (W % 2) != 0 || D != 2) begin : g_param_check
      $error("cmp_serial_arb: W must be even and >= 2, D must be 2");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nx;
   logic [W-1:0]  sa, sb, sa_nx, sb_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          last, last_nx;
   logic [1:0]    gnt_nx;
   logic          busy_nx, done_nx, id_nx, g_nx, e_nx;
   logic          win;
   logic [D-1:0]  da, db;

   // Both requesting: serve the one that did not win last time.
   assign win = req[1] & (~req[0] | ~last);
   assign da  = sa[W-1 -: D];
   assign db  = sb[W-1 -: D];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         sa      <= '0;
         sb      <= '0;
         cnt     <= '0;
         last    <= 1'b1;
         gnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= 1'b0;
         g       <= 1'b0;
         e       <= 1'b0;
      end else begin
         state   <= state_nx;
         sa      <= sa_nx;
         sb      <= sb_nx;
         cnt     <= cnt_nx;
         last    <= last_nx;
         gnt     <= gnt_nx;
         busy    <= busy_nx;
         done    <= done_nx;
         done_id <= id_nx;
         g       <= g_nx;
         e       <= e_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req != 2'b00) state_nx = RUN;
         RUN:     if (da != db || cnt == '0) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Next values for all registered outputs and the datapath.
   always_comb begin
      sa_nx   = sa;
      sb_nx   = sb;
      cnt_nx  = cnt;
      last_nx = last;
      gnt_nx  = 2'b00;
      busy_nx = (state_nx != IDLE);
      done_nx = 1'b0;
      id_nx   = done_id;
      g_nx    = g;
      e_nx    = e;
      case (state)
         IDLE: begin
            if (req != 2'b00) begin
               sa_nx   = win ? a1 : a0;
               sb_nx   = win ? b1 : b0;
               cnt_nx  = CW'(N - 1);
               last_nx = win;
               gnt_nx  = win ? 2'b10 : 2'b01;
            end
         end
         RUN: begin
            if (da != db) begin
               g_nx    = (da > db);
               e_nx    = 1'b0;
               done_nx = 1'b1;
               id_nx   = last;
            end else if (cnt == '0) begin
               g_nx    = 1'b0;
               e_nx    = 1'b1;
               done_nx = 1'b1;
               id_nx   = last;
            end else begin
               sa_nx  = sa << D;
               sb_nx  = sb << D;
               cnt_nx = cnt - CW'(1);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cmp_serial_arb.sv
// Scoreboard bench: a requester/arbiter model predicts grant and done events,
// a separate monitor compares them against the DUT outputs.
module tb_cmp_serial_arb;
   localparam int W = 10;
   localparam int N = W / 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req;
   logic [W-1:0] a0, b0, a1, b1;
   logic [1:0]   gnt;
   logic         busy, done, done_id, g, e;

   always #5 clk = ~clk;

   cmp_serial_arb #(.W(W), .D(2)) dut (
      .clk(clk), .rst(rst), .req(req),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .g(g), .e(e)
   );

   typedef struct {
      int   cyc;
      int   id;
      logic g;
      logic e;
   } exp_t;

   exp_t         gq[$];
   exp_t         dq[$];
   int           total = 0, bad = 0, cyc = 0;
   int           next_idle = 0, last_m = 1, last_gc = -10, drop = -1;
   int           raised[2], served[2];
   logic [W-1:0] oa[2], ob[2];

   assign req = {raised[1] != served[1], raised[0] != served[0]};
   assign a0  = oa[0];
   assign b0  = ob[0];
   assign a1  = oa[1];
   assign b1  = ob[1];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
      for (int k = 0; k < N; k++)
         if (((a >> (W - 2 * (k + 1))) & 3) != ((b >> (W - 2 * (k + 1))) & 3)) return k;
      return N - 1;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Requester + arbiter model: decides the req value sampled at the next edge.
   always @(negedge clk) begin
      int w, k;
      logic [1:0] pend;
      if (rst) begin
         gq.delete();
         dq.delete();
         last_m    = 1;
         next_idle = cyc + 1;
         drop      = -1;
      end else begin
         if (drop >= 0) begin
            served[drop] = served[drop] + 1;
            drop = -1;
         end
         pend = {raised[1] != served[1], raised[0] != served[0]};
         if (cyc >= next_idle && pend != 2'b00) begin
            w = (pend == 2'b11) ? ((last_m == 1) ? 0 : 1) : (pend[1] ? 1 : 0);
            k = first_diff(oa[w], ob[w]);
            gq.push_back('{cyc + 1, w, 1'b0, 1'b0});
            dq.push_back('{cyc + k + 2, w, oa[w] > ob[w], oa[w] == ob[w]});
            next_idle = cyc + k + 3;
            last_m    = w;
            last_gc   = cyc + 1;
            drop      = w;
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      exp_t x;
      if (!rst) begin
         chk("gnt_onehot", 32'($countones(gnt) <= 1), 1);
         if (gnt != 2'b00) begin
            if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
            else begin
               x = gq.pop_front();
               chk("gnt_cycle", cyc, x.cyc);
               chk("gnt_id", 32'(gnt), 32'(1 << x.id));
            end
         end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
            x = gq.pop_front();
            chk("gnt_missing", 32'(gnt), 32'(1 << x.id));
         end
         if (done) begin
            if (dq.size() == 0) chk("done_unexpected", 32'(done), 0);
            else begin
               x = dq.pop_front();
               chk("done_cycle", cyc, x.cyc);
               chk("done_id", 32'(done_id), x.id);
               chk("g", 32'(g), 32'(x.g));
               chk("e", 32'(e), 32'(x.e));
               chk("busy_at_done", 32'(busy), 1);
            end
         end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
            x = dq.pop_front();
            chk("done_missing", 32'(done), 1);
         end
      end
   end

   task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      oa[i] = a;
      ob[i] = b;
      raised[i] = raised[i] + 1;
   endtask

   task automatic wait_quiet();
      int n;
      n = 0;
      while ((req != 2'b00 || cyc < next_idle || dq.size() != 0 || drop >= 0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk("drain_timeout", 32'(dq.size()), 0);
   endtask

   task automatic rnd_ops(output logic [W-1:0] a, output logic [W-1:0] b);
      a = W'($urandom);
      case ($urandom_range(0, 2))
         0:       b = W'($urandom);
         1:       b = a;
         default: b = a ^ (W'(1) << $urandom_range(0, W - 1));
      endcase
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_gnt"}, 32'(gnt), 0);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_done"}, 32'(done), 0);
      chk({nm, "_done_id"}, 32'(done_id), 0);
      chk({nm, "_g"}, 32'(g), 0);
      chk({nm, "_e"}, 32'(e), 0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int issued, n;
      raised[0] = 0; raised[1] = 0; served[0] = 0; served[1] = 0;
      oa[0] = '0; ob[0] = '0; oa[1] = '0; ob[1] = '0;
      rst = 1'b1;
      #2;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // Directed cases
      @(posedge clk); #1; raise(0, 10'h2AA, 10'h2AA); wait_quiet();
      @(posedge clk); #1; raise(0, 10'h300, 10'h0FF); wait_quiet();
      @(posedge clk); #1; raise(1, 10'h001, 10'h002); wait_quiet();
      @(posedge clk); #1; raise(0, 10'h155, 10'h154); raise(1, 10'h3FF, 10'h000); wait_quiet();
      @(posedge clk); #1; raise(0, 10'h010, 10'h020); raise(1, 10'h123, 10'h123); wait_quiet();
      // Request arriving while the engine is running must wait for DONE
      @(posedge clk); #1; raise(0, 10'h0AA, 10'h0AA);
      repeat (2) @(posedge clk);
      #1; raise(1, 10'h200, 10'h100); wait_quiet();

      // Reset in the second RUN cycle of an equal compare
      @(posedge clk); #1; last_gc = -10; raise(0, 10'h1C3, 10'h1C3);
      n = 0;
      do begin
         @(posedge clk); #2;
         n++;
      end while (cyc != last_gc + 1 && n < 50);
      if (n >= 50) chk("rst_run_timeout", n, 0);
      rst = 1'b1;
      #1;
      check_all_zero("rst_mid_run");
      @(posedge clk); #2 rst = 1'b0;
      repeat (8) @(posedge clk);
      #1; raise(0, 10'd5, 10'd3); wait_quiet();

      // Random traffic
      issued = 0;
      n = 0;
      while (issued < 2000 && n < 40000) begin
         @(posedge clk); #1;
         n++;
         for (int i = 0; i < 2; i++) begin
            if (raised[i] == served[i] && !(drop == i) && issued < 2000 &&
                $urandom_range(0, 3) == 0) begin
               rnd_ops(ra, rb);
               raise(i, ra, rb);
               issued++;
            end
         end
      end
      if (n >= 40000) chk("random_budget", issued, 2000);
      wait_quiet();
      chk("gq_empty", 32'(gq.size()), 0);
      chk("dq_empty", 32'(dq.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end
endmodule
